mips_bus_ctrl: RTL

- Bus controller between mips_cpu_bus (Avalon-style master) and two 32x4096 word RAM regions: stack/data at STACK_BASE and program at PROG_BASE.
- Decodes each CPU transaction to one region and generates cpu_waitrequest with a configurable number of wait states.
- Returns captured read data; flags unmapped or illegal accesses.
- Replaces ad-hoc combinational decode in benches and top level, and gives the CPU realistic stall behaviour.

---
 rtl/mips_bus_pkg.sv | 8 +
 rtl/mips_bus_decode.sv | 23 ++
 rtl/mips_bus_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared FSM/region types and default address map for the MIPS bus controller.
package mips_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_STACK, REG_PROG} region_t;
  localparam logic [31:0] DEF_STACK_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_PROG_BASE = 32'hBFC0_0000;
  localparam int DEF_REGION_WORDS = 4096;
endpackage

// File: rtl/mips_bus_decode.sv
// mips_bus_decode: combinational byte-address to region/word-index decode.
module mips_bus_decode
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] STACK_BASE = DEF_STACK_BASE,
  parameter logic [31:0] PROG_BASE = DEF_PROG_BASE,
  parameter int REGION_WORDS = DEF_REGION_WORDS
) (
  input  logic [31:0] i_addr,
  output region_t     o_region,
  output logic [11:0] o_idx
);
  localparam logic [31:0] SPAN = 32'(REGION_WORDS * 4);
  logic [32:0] w_soff, w_poff;
  logic w_hit_s, w_hit_p;
  // The 33rd bit is the borrow, i.e. addr < base, so no constant compare against a zero base.
  assign w_soff = {1'b0, i_addr} - {1'b0, STACK_BASE};
  assign w_poff = {1'b0, i_addr} - {1'b0, PROG_BASE};
  assign w_hit_s = !w_soff[32] && w_soff[31:0] < SPAN;
  assign w_hit_p = !w_poff[32] && w_poff[31:0] < SPAN;
  assign o_region = w_hit_s ? REG_STACK : w_hit_p ? REG_PROG : REG_NONE;
  assign o_idx = w_hit_s ? w_soff[13:2] : w_poff[13:2];
endmodule

// File: rtl/mips_bus_ctrl.sv
// mips_bus_ctrl: decodes CPU bus transactions onto stack/program RAMs with configurable wait states.
// Define MIPS_BUS_JITTER_EN to add 0..3 LFSR-driven extra wait cycles per transaction.
module mips_bus_ctrl
  import mips_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter logic [31:0] STACK_BASE = DEF_STACK_BASE,
  parameter logic [31:0] PROG_BASE = DEF_PROG_BASE,
  parameter int REGION_WORDS = DEF_REGION_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [3:0]  cpu_byteenable,
  input  logic [31:0] cpu_writedata,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic [11:0] stack_address,
  output logic        stack_read,
  output logic        stack_write,
  output logic [3:0]  stack_byteenable,
  output logic [31:0] stack_writedata,
  input  logic [31:0] stack_readdata,
  output logic [11:0] prog_address,
  output logic        prog_read,
  output logic        prog_write,
  output logic [3:0]  prog_byteenable,
  output logic [31:0] prog_writedata,
  input  logic [31:0] prog_readdata,
  output logic        bus_error
);
  state_t r_state, w_next;
  region_t r_region, w_region;
  logic [11:0] r_addr, w_idx;
  logic [3:0] r_be;
  logic [31:0] r_wdata, r_data;
  logic [4:0] r_cnt, w_load;
  logic r_write, r_first, r_err, w_req, w_bad, w_issue;

  mips_bus_decode #(
    .STACK_BASE(STACK_BASE), .PROG_BASE(PROG_BASE), .REGION_WORDS(REGION_WORDS)
  ) u_decode (
    .i_addr(cpu_address), .o_region(w_region), .o_idx(w_idx)
  );

`ifdef MIPS_BUS_JITTER_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_load = 5'(WAIT_STATES) + {3'b0, r_lfsr[1:0]};
`else
  assign w_load = 5'(WAIT_STATES);
`endif

  assign w_req = cpu_read | cpu_write;
  assign w_bad = (w_region == REG_NONE) || (cpu_read && cpu_write);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (r_cnt <= 5'd1) w_next = DONE;
      default: w_next = IDLE;
    endcase
    w_issue = r_state == ISSUE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_region <= REG_NONE;
      r_write <= 1'b0;
      r_addr <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_data <= '0;
      r_cnt <= '0;
      r_first <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_region <= w_bad ? REG_NONE : w_region;
        r_write <= cpu_write;
        r_addr <= w_idx;
        r_be <= cpu_byteenable;
        r_wdata <= cpu_writedata;
        r_data <= '0;
        if (w_bad) r_err <= 1'b1;
      end
      if (w_issue) begin
        r_cnt <= w_load;
        r_first <= 1'b1;
      end
      if (r_state == WAIT) begin
        r_first <= 1'b0;
        r_cnt <= r_cnt - 5'(r_cnt != 5'd0);
        // RAM data is valid only in the cycle right after the strobe.
        if (r_first && !r_write)
          r_data <= r_region == REG_STACK ? stack_readdata : r_region == REG_PROG ? prog_readdata : '0;
      end
    end
  end

  assign cpu_waitrequest = reset && w_req && r_state != DONE;
  assign cpu_readdata = r_state == DONE ? r_data : '0;
  assign stack_read = w_issue && r_region == REG_STACK && !r_write;
  assign stack_write = w_issue && r_region == REG_STACK && r_write;
  assign prog_read = w_issue && r_region == REG_PROG && !r_write;
  assign prog_write = w_issue && r_region == REG_PROG && r_write;
  assign stack_address = r_addr;
  assign prog_address = r_addr;
  assign stack_byteenable = r_be;
  assign prog_byteenable = r_be;
  assign stack_writedata = r_wdata;
  assign prog_writedata = r_wdata;
  assign bus_error = r_err;
endmodule
